// File: rtl/output_vc_credit_tracker.sv
// Per-(port, VC) downstream credit counters feeding the allocator.
// Index order is vc*PORT_CNT + port across all vectors.
module output_vc_credit_tracker #(
  parameter int PORT_CNT  = 5,
  parameter int VC_NUM    = 4,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [0:PORT_CNT*VC_NUM-1]   flit_sent,
  input  logic [0:PORT_CNT*VC_NUM-1]   credit_return,
  output logic [0:PORT_CNT*VC_NUM-1]   nxt_routers_credits,
  output logic [PORT_CNT-1:0]          port_idle,
  output logic [0:PORT_CNT*VC_NUM-1]   credit_underflow,
  output logic [0:PORT_CNT*VC_NUM-1]   credit_overflow
);

  localparam int N = PORT_CNT * VC_NUM;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [0:N-1] full;

  for (genvar i = 0; i < N; i++) begin : g_slice
    logic [CNT_W-1:0] cnt;
    logic             dec;
    logic             inc;
    logic             empty;

    assign dec   = flit_sent[i] & ~credit_return[i];
    assign inc   = credit_return[i] & ~flit_sent[i];
    assign empty = (cnt == '0);

    // Send plus return in one cycle nets to zero, so neither flag fires.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt                 <= FULL;
        credit_underflow[i] <= 1'b0;
        credit_overflow[i]  <= 1'b0;
      end else begin
        unique case (1'b1)
          dec && !empty:  cnt <= cnt - 1'b1;
          dec && empty:   credit_underflow[i] <= 1'b1;
          inc && !full[i]: cnt <= cnt + 1'b1;
          inc && full[i]: credit_overflow[i] <= 1'b1;
          default: ;
        endcase
      end
    end

    assign full[i]                = (cnt == FULL);
    assign nxt_routers_credits[i] = ~empty;
  end

  for (genvar p = 0; p < PORT_CNT; p++) begin : g_port
    logic [VC_NUM-1:0] vc_full;
    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
      assign vc_full[v] = full[v*PORT_CNT + p];
    end
    assign port_idle[p] = &vc_full;
  end

endmodule

// File: doc/output_vc_credit_tracker.md
Name: output_vc_credit_tracker

Overview:
- Per-output-port, per-VC credit bookkeeping stage that sits directly downstream of the all-VC priority/switch allocator in the router.
- Counts free buffer slots in the next router's input VCs:
  - decrements a count when the allocator forwards a flit on a (port, VC);
  - increments it when the next router returns a credit.
- Produces the registered-state-derived nxt_routers_credits vector the allocator consumes on the next cycle.
- Flags protocol violations (underflow/overflow) for debug.

Parameters:
- PORT_CNT, 5, number of router in/out ports (matches `IN_OUTPORT_CNT).
- VC_NUM, 4, virtual channels per port.
- BUF_DEPTH, 4, flit slots per VC in the next router's input buffer; credit counter reset value; legal range 1..15.
- CNT_W, 3, counter width; must satisfy 2^CNT_W > BUF_DEPTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flit_sent  input  PORT_CNT*VC_NUM  one bit per (port, VC). Set in the cycle a flit leaves on that output VC.
- credit_return  input  PORT_CNT*VC_NUM  one bit per (port, VC). Set in the cycle the next router frees one slot.
- nxt_routers_credits  output  PORT_CNT*VC_NUM  1 = at least one free slot downstream on that (port, VC).
- port_idle  output  PORT_CNT  1 = every VC of that port holds BUF_DEPTH credits.
- credit_underflow  output  PORT_CNT*VC_NUM  sticky error flag per (port, VC).
- credit_overflow  output  PORT_CNT*VC_NUM  sticky error flag per (port, VC).

All per-(port, VC) vectors use bit order [0 : PORT_CNT*VC_NUM-1]:
- bits [0 : PORT_CNT-1] are VC 0;
- bits [PORT_CNT : 2*PORT_CNT-1] are VC 1;
- and so on, so index = vc*PORT_CNT + port.

Behaviour:
Reset (rst=1 at a clk edge):
- All counters load BUF_DEPTH.
- All error flags clear.
- rst overrides any concurrent flit_sent/credit_return; those inputs are discarded.
- Outputs one cycle after the reset edge: nxt_routers_credits all 1, port_idle all 1, credit_underflow/credit_overflow all 0.
- Reset asserted mid-traffic behaves identically: in-flight sends and returns are lost and counters reload.

Counter update per (port, VC), evaluated every edge with rst=0:
- sent=0, ret=0: count holds.
- sent=1, ret=0, count>0: count-1.
- sent=1, ret=0, count=0: count holds at 0; underflow flag set.
- sent=0, ret=1, count<BUF_DEPTH: count+1.
- sent=0, ret=1, count=BUF_DEPTH: count holds (saturates); overflow flag set.
- sent=1, ret=1: count holds, at any value including 0 and BUF_DEPTH. No flag is set, because the send consumes the returned slot.

Outputs and latency:
- nxt_routers_credits[i] = (count[i] != 0), decoded combinationally from the counter register. There is no input-to-output combinational path.
- A send that drains the last credit deasserts the bit on the edge after the send cycle, so the allocator cannot issue a second flit on that VC in the next cycle.
- A credit return on count=0 reasserts the bit one edge later.
- port_idle[p] = AND over v of (count[v*PORT_CNT+p] == BUF_DEPTH). Registered-state-derived, same latency.
- Error flags are sticky until rst.
- Counters for different (port, VC) pairs are fully independent; any number may update in the same cycle.
- Counter arithmetic is unsigned CNT_W-bit and never wraps: saturating at 0 and at BUF_DEPTH as above.

Implementation constraint:
- Generate loop over VC_NUM*PORT_CNT instances of one counter slice plus the port_idle reduction.
- No other state.

Test Plan:
1. Reset and idle: hold rst 2 cycles, then release with no traffic.
   -> nxt_routers_credits all 1, port_idle = 5'b11111, both flag vectors 0, stable for 10 cycles.
2. Drain one VC: pulse flit_sent[idx 6] (VC1, port1) for 4 consecutive cycles with BUF_DEPTH=4.
   -> nxt_routers_credits[6] goes 0 on the edge after the 4th pulse.
   -> port_idle[1] goes 0 after the 1st pulse.
   -> all other bits unchanged.
   Then one credit_return[6] -> bit 6 back to 1 one edge later.
3. Simultaneous send and return at count=0 and at count=BUF_DEPTH: assert both on idx 0 for 3 cycles at each level.
   -> counter unchanged, nxt_routers_credits[0] unchanged, no flags.
4. Violations:
   - Send on idx 3 at count 0 -> credit_underflow[3]=1 and stays 1; count stays 0.
   - Return on idx 12 at count 4 -> credit_overflow[12]=1; count stays 4.
   - Both flags clear only after rst.
5. Reset mid-operation: drive random sends/returns on all 20 bits with rst asserted in cycle 50.
   -> next cycle all counters = 4, outputs as in scenario 1, inputs in the reset cycle ignored.
6. Random stress: 10k cycles of legal traffic (send only when credit=1, return only when outstanding>0), checked against a scoreboard model.
   -> exact per-(port, VC) count match, no flags ever set.
